// File: rtl/clock_pkg.sv
// Shared types and timing defaults for the clock set-mode controller.
// BLINK_HALF exists only when CLOCK_SET_BLINK_EN is defined.
package clock_pkg;

    localparam int NUM_FIELDS_DEFAULT    = 6;
    localparam int REPEAT_DELAY_DEFAULT  = 500;
    localparam int REPEAT_PERIOD_DEFAULT = 100;
    localparam int TIMEOUT_DEFAULT       = 10000;
`ifdef CLOCK_SET_BLINK_EN
    localparam int BLINK_HALF            = 500;
`endif

    typedef enum logic [2:0] {
        FLD_SEC   = 3'd0,
        FLD_MIN   = 3'd1,
        FLD_HOUR  = 3'd2,
        FLD_DAY   = 3'd3,
        FLD_MONTH = 3'd4,
        FLD_YEAR  = 3'd5
    } field_e;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    // RUN ignores the field; SET(k) carries k in the field member.
    typedef struct packed {
        mode_e  mode;
        field_e field;
    } state_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/timebase inputs and set-mode outputs of clock_set_ctrl.
// master drives buttons and tick; slave is the controller.
interface clock_set_ctrl_if
    import clock_pkg::*;
#(
    parameter int NUM_FIELDS = NUM_FIELDS_DEFAULT
);
    logic                  tick;
    logic                  btn_mode;
    logic                  btn_up;
    logic                  btn_down;
    logic [NUM_FIELDS-1:0] set_sel;
    logic                  inc;
    logic                  dec;
    logic                  run;
    logic                  blink;

    modport master (
        output tick, btn_mode, btn_up, btn_down,
        input  set_sel, inc, dec, run, blink
    );

    modport slave (
        input  tick, btn_mode, btn_up, btn_down,
        output set_sel, inc, dec, run, blink
    );
endinterface

// File: rtl/btn_repeat.sv
// Rising-edge detect plus press-and-hold auto-repeat for one level button.
// pulse is combinational; the parent registers it.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    input  logic clear,
    output logic pulse
);
    localparam int CW = $clog2(REPEAT_DELAY) + 1;
    localparam logic [CW-1:0] HOLD_LAST   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic          prev_q, prev_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          press;
    logic          rpt_hit;

    // After the first repeat the counter is rewound so later repeats land every REPEAT_PERIOD ticks.
    always_comb begin
        prev_d  = btn;
        press   = btn & ~prev_q;
        rpt_hit = 1'b0;
        hold_d  = hold_q;
        if (clear || !btn) begin
            hold_d = '0;
        end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
                rpt_hit = 1'b1;
                hold_d  = HOLD_RELOAD;
            end else if (hold_q != '1) begin
                hold_d = hold_q + 1'b1;
            end
        end
        pulse = press | rpt_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            hold_q <= '0;
        end else begin
            prev_q <= prev_d;
            hold_q <= hold_d;
        end
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller: steps RUN -> SET(0..N-1) -> RUN on mode presses, issues inc/dec pulses.
// Optional display blink is built only when CLOCK_SET_BLINK_EN is defined.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_FIELDS    = NUM_FIELDS_DEFAULT,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter int TIMEOUT       = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    clock_set_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_END  = TW'(TIMEOUT);

    state_t                state_q, state_d;
    logic                  mode_prev_q, mode_prev_d;
    logic [TW-1:0]         to_q, to_d;
    logic [NUM_FIELDS-1:0] set_sel_q, set_sel_d;
    logic                  run_q, run_d, inc_q, inc_d, dec_q, dec_d;
    logic                  mode_press, both, hold_clear, up_pulse, down_pulse;
    logic                  in_set, activity, timeout_hit;

    assign mode_press = bus.btn_mode & ~mode_prev_q;
    assign both       = bus.btn_up & bus.btn_down;
    assign hold_clear = both | mode_press;

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
        .clk(clk), .rst_n(rst_n), .tick(bus.tick), .btn(bus.btn_up),
        .clear(hold_clear), .pulse(up_pulse)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
        .clk(clk), .rst_n(rst_n), .tick(bus.tick), .btn(bus.btn_down),
        .clear(hold_clear), .pulse(down_pulse)
    );

    always_comb begin
        state_d     = state_q;
        mode_prev_d = bus.btn_mode;
        to_d        = to_q;
        timeout_hit = 1'b0;
        in_set      = (state_q.mode == MODE_SET);
        activity    = mode_press | bus.btn_up | bus.btn_down;

        if (!in_set || activity) begin
            to_d = '0;
        end else if (bus.tick) begin
            timeout_hit = (to_q == TO_LAST);
            if (to_q != TO_END) to_d = to_q + 1'b1;
        end

        if (mode_press) begin
            if (!in_set)
                state_d = '{mode: MODE_SET, field: FLD_SEC};
            else if (int'(state_q.field) == NUM_FIELDS - 1)
                state_d = '{mode: MODE_RUN, field: FLD_SEC};
            else
                state_d.field = field_e'(state_q.field + 3'd1);
        end else if (timeout_hit) begin
            state_d = '{mode: MODE_RUN, field: FLD_SEC};
        end

        set_sel_d = '0;
        if (state_d.mode == MODE_SET) set_sel_d[state_d.field] = 1'b1;
        run_d = (state_d.mode == MODE_RUN);

        // A mode press or both buttons held swallows any pending up/down pulse.
        inc_d = in_set & ~mode_press & ~both & up_pulse;
        dec_d = in_set & ~mode_press & ~both & down_pulse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '{mode: MODE_RUN, field: FLD_SEC};
            mode_prev_q <= 1'b1;
            to_q        <= '0;
            set_sel_q   <= '0;
            run_q       <= 1'b1;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= mode_prev_d;
            to_q        <= to_d;
            set_sel_q   <= set_sel_d;
            run_q       <= run_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
        end
    end

    assign bus.set_sel = set_sel_q;
    assign bus.run     = run_q;
    assign bus.inc     = inc_q;
    assign bus.dec     = dec_q;

`ifdef CLOCK_SET_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF) + 1;

    logic [BW-1:0] phase_cnt_q, phase_cnt_d, vis_cnt_q, vis_cnt_d;
    logic          phase_q, phase_d, blink_q, blink_d;

    // vis_cnt keeps the field solid for BLINK_HALF ticks after each adjustment.
    always_comb begin
        phase_cnt_d = phase_cnt_q;
        vis_cnt_d   = vis_cnt_q;
        phase_d     = phase_q;
        if (state_d.mode == MODE_RUN) begin
            phase_cnt_d = '0;
            vis_cnt_d   = '0;
            phase_d     = 1'b0;
        end else begin
            if (inc_d || dec_d)
                vis_cnt_d = BW'(BLINK_HALF);
            else if (bus.tick && vis_cnt_q != '0)
                vis_cnt_d = vis_cnt_q - 1'b1;
            if (bus.tick) begin
                if (phase_cnt_q == BW'(BLINK_HALF - 1)) begin
                    phase_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
        end
        blink_d = (state_d.mode == MODE_SET) & (phase_d | (vis_cnt_d != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_q <= '0;
            vis_cnt_q   <= '0;
            phase_q     <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            vis_cnt_q   <= vis_cnt_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.blink = blink_q;
`else
    assign bus.blink = 1'b0;
`endif
endmodule

// File: doc/clock_set_ctrl.md
Name:
clock_set_ctrl

Overview:
- Set-mode controller for the clock's time-of-day and date counters.
- Turns three debounced level buttons (mode, up, down) into three outputs:
  - a one-hot per-field set select, driving each counter's ctrl_set;
  - single-cycle inc/dec pulses shared by all counters;
  - a run indicator.
- Sits between the button debouncers and the counter chain.
- Provides press-and-hold auto-repeat and an inactivity timeout back to run mode.

Parameters:
- NUM_FIELDS, 6, number of settable fields. Field order: 0=sec, 1=min, 2=hour, 3=day, 4=month, 5=year.
- REPEAT_DELAY, 500, ticks a button must be held before auto-repeat starts.
- REPEAT_PERIOD, 100, ticks between auto-repeat pulses.
- TIMEOUT, 10000, ticks without any button press before an automatic return to RUN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- tick  in  1  one-clk-wide 1 kHz timebase strobe.
- btn_mode  in  1  debounced mode button, level, active-high.
- btn_up  in  1  debounced up button, level, active-high.
- btn_down  in  1  debounced down button, level, active-high.
- set_sel  out  NUM_FIELDS  one-hot ctrl_set per field; all zero in RUN.
- inc  out  1  one-clk increment pulse to the selected counter.
- dec  out  1  one-clk decrement pulse to the selected counter.
- run  out  1  high when the clock is free-running.
- blink  out  1  display blink for the selected field (see Optional Feature).

Behaviour:
- Reset values: state=RUN, set_sel=0, inc=0, dec=0, run=1, blink=0.
- Button previous-value registers reset to 1. A button already held at reset release therefore produces no press.
- A press is a rising edge of a button, detected on clk.
- State machine: RUN and SET(k), with k in 0..NUM_FIELDS-1. All outputs are registered.
  - RUN, mode press: go to SET(0).
  - SET(k), mode press with k<NUM_FIELDS-1: go to SET(k+1).
  - SET(NUM_FIELDS-1), mode press: go to RUN.
  - SET(k), timeout counter reaches TIMEOUT: go to RUN.
- Latency: press detected in cycle N → set_sel/run update in cycle N+1.
- Outputs per state: set_sel[k]=1 and run=0 in SET(k); set_sel=0 and run=1 in RUN.
- inc/dec are generated only in SET states. Up/down presses in RUN are ignored and create no pulses.
- Press pulse: up press in cycle N → inc=1 in cycle N+1 only. Down press behaves the same on dec.
- Auto-repeat:
  - Hold counter counts ticks while the button stays high.
  - First repeat pulse comes when the count reaches REPEAT_DELAY.
  - Further pulses come every REPEAT_PERIOD ticks after that.
  - Releasing the button clears the hold counter.
- up and down both high: no inc or dec. Both hold counters are cleared. The first press edge after release is honoured again.
- Mode press in the same cycle as an up/down press or repeat: the mode transition wins, no inc/dec is issued, and hold counters are cleared.
- inc and dec are never high together. Each lasts exactly one clk.
- Timeout counter:
  - counts ticks while in SET;
  - is cleared by any press or by an active hold;
  - saturates, never wraps.
- Hold and timeout counters are sized with $clog2 of their parameter plus 1, and saturate.
- rst_n asserted mid-operation: immediate return to reset values, whatever the state or pending pulse.

Optional Feature:
- Macro: CLOCK_SET_BLINK_EN.
- Defined: blink toggles every 500 ticks while in SET. It is forced to 1 for 500 ticks after any inc/dec, so a field being adjusted stays visible. blink=0 in RUN.
- Undefined: blink is tied to 0 and no blink counter is built.

Decomposition:
- Package clock_pkg:
  - field index constants FLD_SEC..FLD_YEAR;
  - NUM_FIELDS default;
  - state typedef (RUN plus the SET encoding);
  - tick-based timing defaults.
- Sub-module btn_repeat, instantiated for up and for down: edge detect, hold counter, press/repeat pulse output, clear input.

Test Plan:
- Reset, then mode pressed 7 times → set_sel steps 000001, 000010, 000100, 001000, 010000, 100000, then 000000 with run=1.
- SET(1), up pressed for 1 clk then released → exactly one inc pulse, one cycle after the edge; dec stays 0.
- SET(2), down held for 800 ticks → 1 press pulse plus repeats at ticks 500, 600, 700, 800: 5 dec pulses total.
- SET(0), no input for 10000 ticks → return to RUN at tick 10000. With an up press at tick 9999, still in SET at tick 10001.
- SET(3), up and down held together for 1000 ticks → no inc/dec. Mode and up pressed in the same cycle → SET(4), no inc.
- btn_up held high through reset release → no inc. rst_n pulsed during SET(5) with down held → RUN, all outputs at reset values.
